// File: rtl/rca_response_checker.sv
// Checks a 4-bit ripple-carry adder's {Cout,S} against A+B+Cin over one NUM_VEC-sample sweep.
// Optional input-sequence checking is enabled by defining RCA_CHK_ORDER_EN.
module rca_response_checker #(
    parameter int NUM_VEC = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sample_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    input  logic [3:0] S,
    input  logic       Cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [9:0] vec_count,
    output logic [8:0] first_fail,
    output logic       first_fail_vld,
    output logic       order_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [9:0] LAST_CNT = 10'(NUM_VEC - 1);
    localparam logic [9:0] ERR_MAX  = 10'h3FF;

    state_e     state_q, state_d;
    logic [9:0] err_count_q, err_count_d;
    logic [9:0] vec_count_q, vec_count_d;
    logic [8:0] first_fail_q, first_fail_d;
    logic       first_fail_vld_q, first_fail_vld_d;

    logic [4:0] expected;
    logic       mismatch;
    logic       accept;
    logic       restart;

    assign expected = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
    assign mismatch = (expected != {Cout, S});
    assign accept   = (state_q == RUN) && sample_valid;
    // A start seen in RUN is ignored, so only IDLE/DONE can restart.
    assign restart  = (state_q != RUN) && start;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path can infer a latch.
        state_d          = state_q;
        err_count_d      = err_count_q;
        vec_count_d      = vec_count_q;
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d          = RUN;
                    err_count_d      = '0;
                    vec_count_d      = '0;
                    first_fail_d     = '0;
                    first_fail_vld_d = 1'b0;
                end
            end
            RUN: begin
                if (sample_valid) begin
                    vec_count_d = vec_count_q + 10'd1;
                    if (mismatch) begin
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + 10'd1;
                        end
                        if (!first_fail_vld_q) begin
                            first_fail_d     = {A, B, Cin};
                            first_fail_vld_d = 1'b1;
                        end
                    end
                    if (vec_count_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q          <= IDLE;
            err_count_q      <= '0;
            vec_count_q      <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            err_count_q      <= err_count_d;
            vec_count_q      <= vec_count_d;
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
        end
    end

`ifdef RCA_CHK_ORDER_EN
    logic [8:0] idx_q, idx_d;
    logic       order_err_q, order_err_d;

    always_comb begin
        idx_d       = idx_q;
        order_err_d = order_err_q;
        if (restart) begin
            idx_d       = '0;
            order_err_d = 1'b0;
        end else if (accept) begin
            idx_d = idx_q + 9'd1;
            if ({A, B, Cin} != idx_q) begin
                order_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            order_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    logic unused_restart;
    assign unused_restart = restart;
    assign order_err      = 1'b0;
`endif

    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_count_q == '0) && !order_err;
    assign err_count      = err_count_q;
    assign vec_count      = vec_count_q;
    assign first_fail     = first_fail_q;
    assign first_fail_vld = first_fail_vld_q;

    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_rca_response_checker.sv
// Self-checking bench for rca_response_checker: randomized sweeps scored against a behavioural model.
module tb_rca_response_checker;

    localparam int NV = 512;
`ifdef RCA_CHK_ORDER_EN
    localparam bit ORDER_EN = 1'b1;
`else
    localparam bit ORDER_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       sample_valid = 1'b0;
    logic [3:0] A = '0, B = '0, S = '0;
    logic       Cin = 1'b0, Cout = 1'b0;
    logic       busy, done, pass, first_fail_vld, order_err;
    logic [9:0] err_count, vec_count;
    logic [8:0] first_fail;

    int n_checks = 0;
    int n_fail   = 0;

    rca_response_checker #(.NUM_VEC(NV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sample_valid   (sample_valid),
        .A              (A),
        .B              (B),
        .Cin            (Cin),
        .S              (S),
        .Cout           (Cout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .vec_count      (vec_count),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld),
        .order_err      (order_err)
    );

    always #5 clk = ~clk;

    // Modes: 0 good adder, 1 sum bit0 stuck at 0, 2 random corruption + gaps,
    // 3 samples 5/6 swapped, 4 gaps with stray start pulses and a start+valid launch.
    // Inputs change on the falling edge; outputs are observed on the following falling edge.
    task automatic run_sweep(input int mode, input int n_samp,
                             output int e_err, output logic [8:0] e_first,
                             output logic e_fvld, output logic e_order,
                             output int prog_bad);
        int raw;
        int good;
        int got;
        int gap;
        logic [8:0] v;
        raw = 0; e_first = '0; e_fvld = 1'b0; e_order = 1'b0; prog_bad = 0;
        @(negedge clk);
        start = 1'b1;
        // A launch sample that would be a mismatch if it were ever checked.
        sample_valid = (mode == 4);
        {A, B, Cin} = 9'h1FF; {Cout, S} = 5'd0;
        @(negedge clk);
        start = 1'b0; sample_valid = 1'b0;
        if (vec_count !== 10'd0 || busy !== 1'b1 || done !== 1'b0) prog_bad++;
        for (int i = 0; i < n_samp; i++) begin
            gap = 0;
            if ((mode == 2 || mode == 4) && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
            for (int j = 0; j < gap; j++) begin
                {A, B, Cin} = 9'($urandom); {Cout, S} = 5'($urandom);
                start = (mode == 4 && j == 0);
                @(negedge clk);
                start = 1'b0;
                if (vec_count !== 10'(i) || busy !== 1'b1 || done !== 1'b0) prog_bad++;
            end
            v = 9'(i);
            if (mode == 3 && i == 5) v = 9'd6;
            if (mode == 3 && i == 6) v = 9'd5;
            good = int'(v[8:5]) + int'(v[4:1]) + int'(v[0]);
            got  = good;
            if (mode == 1) got = good & 30;
            if (mode == 2 && $urandom_range(0, 7) == 0) got = good ^ $urandom_range(1, 31);
            {A, B, Cin} = v;
            {Cout, S}   = 5'(got);
            sample_valid = 1'b1;
            start = (mode == 4 && i == 200);
            if (got != good) begin
                raw++;
                if (!e_fvld) begin
                    e_fvld  = 1'b1;
                    e_first = v;
                end
            end
            if (ORDER_EN && v != 9'(i)) e_order = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0; start = 1'b0;
            if (vec_count !== 10'(i + 1) || busy !== (i + 1 != NV) || done !== (i + 1 == NV)) prog_bad++;
        end
        e_err = (raw > 1023) ? 1023 : raw;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, pass, err_count, vec_count, first_fail, first_fail_vld, order_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b err=%0d vec=%0d ff=%h ffv=%b oe=%b, expected all 0",
                     busy, done, pass, err_count, vec_count, first_fail, first_fail_vld, order_err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_sweep(input string name, input int mode);
        int e_err, prog_bad;
        logic [8:0] e_first;
        logic e_fvld, e_order, e_pass;
        run_sweep(mode, NV, e_err, e_first, e_fvld, e_order, prog_bad);
        e_pass = (e_err == 0) && !e_order;
        n_checks++;
        if (prog_bad !== 0) begin
            n_fail++; $display("FAIL %s_progress: %0d bad cycles, expected 0", name, prog_bad);
        end
        n_checks++;
        if (done !== 1'b1 || vec_count !== 10'(NV)) begin
            n_fail++; $display("FAIL %s_done: got done=%b vec=%0d, expected 1 %0d", name, done, vec_count, NV);
        end
        n_checks++;
        if (err_count !== 10'(e_err)) begin
            n_fail++; $display("FAIL %s_err_count: got %0d expected %0d", name, err_count, e_err);
        end
        n_checks++;
        if (first_fail_vld !== e_fvld || (e_fvld && first_fail !== e_first)) begin
            n_fail++; $display("FAIL %s_first_fail: got vld=%b ff=%h expected vld=%b ff=%h",
                               name, first_fail_vld, first_fail, e_fvld, e_first);
        end
        n_checks++;
        if (order_err !== e_order || pass !== e_pass) begin
            n_fail++; $display("FAIL %s_pass: got oe=%b pass=%b expected oe=%b pass=%b",
                               name, order_err, pass, e_order, e_pass);
        end
    endtask

    task automatic test_sum_bit0();
        int odd;
        odd = 0;
        for (int i = 0; i < NV; i++) if (((i >> 5) + ((i >> 1) & 15) + (i & 1)) % 2 == 1) odd++;
        test_sweep("bit0", 1);
        n_checks++;
        if (err_count !== 10'(odd) || err_count !== 10'd256 || first_fail !== 9'h001) begin
            n_fail++; $display("FAIL bit0_known: got err=%0d ff=%h expected 256 001", err_count, first_fail);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int e_err, prog_bad;
        logic [8:0] e_first;
        logic e_fvld, e_order;
        run_sweep(2, 100, e_err, e_first, e_fvld, e_order, prog_bad);
        n_checks++;
        if (prog_bad !== 0 || vec_count !== 10'd100 || err_count !== 10'(e_err)) begin
            n_fail++; $display("FAIL mid_partial: got bad=%0d vec=%0d err=%0d expected 0 100 %0d",
                               prog_bad, vec_count, err_count, e_err);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, pass, err_count, vec_count, first_fail, first_fail_vld, order_err} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got busy=%b err=%0d vec=%0d ffv=%b, expected all 0",
                               busy, err_count, vec_count, first_fail_vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || vec_count !== 10'd0) begin
            n_fail++; $display("FAIL mid_needs_start: got busy=%b vec=%0d expected 0 0", busy, vec_count);
        end
        test_sweep("after_reset", 0);
    endtask

    task automatic test_ignore();
        {A, B, Cin} = 9'h1FF; {Cout, S} = 5'd0;
        sample_valid = 1'b1;
        repeat (3) @(negedge clk);
        sample_valid = 1'b0;
        n_checks++;
        if (vec_count !== 10'(NV) || err_count !== 10'd0 || done !== 1'b1) begin
            n_fail++; $display("FAIL ignore_done_valid: got vec=%0d err=%0d done=%b expected %0d 0 1",
                               vec_count, err_count, done, NV);
        end
        test_sweep("stray_start", 4);
    endtask

    initial begin
        test_reset();
        test_sweep("good", 0);
        test_ignore();
        test_sum_bit0();
        test_sweep("random", 2);
        test_sweep("swap", 3);
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/rca_response_checker.md
RCA_RESPONSE_CHECKER -- requirements
Module: rca_response_checker

Interface
REQ-001 The block SHALL have parameter NUM_VEC, default 512, giving the number of samples in one sweep (legal range 1..512).
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a sweep.
REQ-005 The block SHALL have port sample_valid, input, 1 bit: the current A/B/Cin/S/Cout set is to be checked.
REQ-006 The block SHALL have ports A and B, each input, 4 bits: adder operands.
REQ-007 The block SHALL have port Cin, input, 1 bit: adder carry-in.
REQ-008 The block SHALL have port S, input, 4 bits: adder sum under test.
REQ-009 The block SHALL have port Cout, input, 1 bit: adder carry-out under test.
REQ-010 The block SHALL have port busy, output, 1 bit: sweep in progress.
REQ-011 The block SHALL have port done, output, 1 bit: sweep finished; held until next start.
REQ-012 The block SHALL have port pass, output, 1 bit: done with zero errors.
REQ-013 The block SHALL have port err_count, output, 10 bits: mismatching samples, saturating.
REQ-014 The block SHALL have port vec_count, output, 10 bits: samples accepted this sweep.
REQ-015 The block SHALL have port first_fail, output, 9 bits: {A,B,Cin} of the first mismatching sample.
REQ-016 The block SHALL have port first_fail_vld, output, 1 bit: first_fail holds a captured value.
REQ-017 The block SHALL have port order_err, output, 1 bit: a sample arrived out of sequence.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE; busy=1 only in RUN, and done=1 only in DONE.
REQ-019 start=1 in IDLE or DONE SHALL, on the next edge, enter RUN and clear err_count, vec_count, first_fail, first_fail_vld and order_err.
REQ-020 start=1 while in RUN SHALL be ignored.
REQ-021 In RUN, each edge with sample_valid=1 SHALL compute expected = A+B+Cin as a 5-bit value and compare it with {Cout,S}.
REQ-022 Each accepted sample SHALL increment vec_count and be reflected one cycle after the sampling edge.
REQ-023 On a mismatch, err_count SHALL increment, saturating at 1023.
REQ-024 On the first mismatch of a sweep, {A,B,Cin} SHALL be latched into first_fail and first_fail_vld SHALL be set; later mismatches SHALL NOT overwrite them.
REQ-025 The edge that accepts sample number NUM_VEC SHALL move the FSM to DONE, with done visible in the next cycle.
REQ-026 pass SHALL equal done AND (err_count==0) AND NOT order_err.
REQ-027 sample_valid outside RUN SHALL be ignored, with no counter change.
REQ-028 start and sample_valid asserted together in IDLE or DONE SHALL start the sweep only; that sample SHALL NOT be checked.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, force state IDLE and drive every output to 0.
REQ-030 Reset asserted mid-sweep SHALL discard all progress; a new start is then required.

Configuration
REQ-031 With macro RCA_CHK_ORDER_EN defined, an internal 9-bit index SHALL start at 0 and increment per accepted sample.
REQ-032 With RCA_CHK_ORDER_EN defined, a sample whose {A,B,Cin} differs from the index SHALL set order_err, which stays set until the next start or reset; arithmetic checking SHALL be unaffected.
REQ-033 Without RCA_CHK_ORDER_EN, order_err SHALL be tied to 0 and no index logic SHALL exist.

Verification
REQ-034 Correct adder, 512 in-order samples with {A,B,Cin}=0..511 -> done=1, pass=1, err_count=0, vec_count=512.
REQ-035 Sum bit 0 forced to 0, full sweep -> err_count=256, first_fail=9'h001, first_fail_vld=1, pass=0.
REQ-036 Reset pulsed after 100 samples, then restarted with 512 good samples -> all outputs 0 during reset; final vec_count=512, pass=1.
REQ-037 With RCA_CHK_ORDER_EN defined, good sums but samples 5 and 6 swapped -> order_err=1, err_count=0, pass=0.
REQ-038 start pulsed mid-sweep, and sample_valid asserted while in IDLE -> no effect on the counters; done asserts only after sample 512.
